// File: rtl/cnu_msg_gen.sv
// cnu_msg_gen
// Expands one compressed check-node record into DEG c2v messages.
// Offset-min-sum is used. One record is {min1, min2, idx, signs}.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   record handshake
//   in_min              {min2, min1}; min1 sits in the low DATA_W bits
//   in_idx              edge index that holds min1
//   in_signs            v2c sign bits; bit e belongs to edge e
//   out_valid/out_ready message handshake
//   out_msg             sign-magnitude message {sign, mag}
//   out_edge            edge index of out_msg
//   out_last            high on the edge DEG-1 beat
//
// Handshake rule, on both sides: a transfer happens on a rising edge
// where valid && ready. A producer holding valid keeps its payload
// stable until that transfer. out_* are registered. in_ready is
// combinational: the upstream may push into a full FIFO in the same
// cycle that the head record pops.
module cnu_msg_gen #(
  parameter int DATA_W = 9,
  parameter int IDX_W  = 3,
  parameter int DEG    = 8,
  parameter int OFFSET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DATA_W-1:0]   in_min,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic [DEG-1:0]        in_signs,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W:0]       out_msg,
  output logic [IDX_W-1:0]      out_edge,
  output logic                  out_last
);

  localparam logic [DATA_W-1:0] OFF    = DATA_W'(OFFSET);
  localparam logic [IDX_W:0]    DEG_W  = (IDX_W+1)'(DEG);
  localparam logic [IDX_W-1:0]  LAST_E = IDX_W'(DEG-1);

  typedef struct packed {
    logic [DATA_W-1:0] min1;
    logic [DATA_W-1:0] min2;
    logic [IDX_W-1:0]  idx;
    logic [DEG-1:0]    signs;
    logic              sign_total;
  } rec_t;

  typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [1:0]        count_q, count_d;
  rec_t              e0_q, e0_d, e1_q, e1_d;
  rec_t              in_rec;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [DATA_W:0]   msg_q, msg_d;
  logic              last_q, last_d;
  logic              fire, last_fire, push, pop;

  // Build one message from a record.
  // An idx outside 0..DEG-1 never matches an edge, so every edge uses min1.
  function automatic logic [DATA_W:0] beat(input rec_t r, input logic [IDX_W-1:0] e);
    logic [DATA_W-1:0] sel;
    logic [DATA_W-1:0] mag;
    sel = (({1'b0, r.idx} < DEG_W) && (r.idx == e)) ? r.min2 : r.min1;
    mag = (sel > OFF) ? sel - OFF : '0;
    return {r.sign_total ^ r.signs[e], mag};
  endfunction

  assign fire      = valid_q && out_ready;
  assign last_fire = fire && last_q;
  assign pop       = last_fire;
  assign in_ready  = (count_q != 2'd2) || last_fire;
  assign push      = in_valid && in_ready;

  assign out_valid = valid_q;
  assign out_msg   = msg_q;
  assign out_edge  = cnt_q;
  assign out_last  = last_q;

  always_comb begin
    in_rec            = '0;
    in_rec.min1       = in_min[DATA_W-1:0];
    in_rec.min2       = in_min[2*DATA_W-1:DATA_W];
    in_rec.idx        = in_idx;
    in_rec.signs      = in_signs;
    in_rec.sign_total = ^in_signs;
  end

  // 2-entry FIFO. e0 is always the head, so a pop shifts e1 down.
  // The FIFO cannot be full when a push occurs without a pop,
  // because in_ready is low in that case.
  always_comb begin
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) e0_d = in_rec;
        else                 e1_d = in_rec;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        e0_d    = e1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          e0_d = in_rec;
        end else begin
          e0_d = e1_q;
          e1_d = in_rec;
        end
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      msg_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      msg_q   <= msg_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (count_d != 2'd0) state_d = S_EMIT;
      S_EMIT: if (last_fire && (count_d == 2'd0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic.
  // Messages are computed from the post-update head (e0_d).
  // This lets a record captured into an empty FIFO show edge 0 on the
  // next cycle, and lets the next record follow a last beat with no gap.
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (count_d != 2'd0) begin
          valid_d = 1'b1;
          cnt_d   = '0;
          msg_d   = beat(e0_d, '0);
          last_d  = (LAST_E == '0);
        end
      end
      S_EMIT: begin
        if (last_fire) begin
          cnt_d = '0;
          if (count_d != 2'd0) begin
            valid_d = 1'b1;
            msg_d   = beat(e0_d, '0);
            last_d  = (LAST_E == '0);
          end else begin
            valid_d = 1'b0;
            msg_d   = '0;
            last_d  = 1'b0;
          end
        end else if (fire) begin
          cnt_d  = cnt_q + 1'b1;
          msg_d  = beat(e0_d, cnt_q + 1'b1);
          last_d = ((cnt_q + 1'b1) == LAST_E);
        end
      end
      default: begin
        valid_d = 1'b0;
        cnt_d   = '0;
        msg_d   = '0;
        last_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cnu_msg_gen.sv
module tb_cnu_msg_gen;

  localparam int DATA_W = 9;
  localparam int IDX_W  = 3;
  localparam int DEG    = 8;
  localparam int DEG6   = 6;
  localparam int OFFSET = 1;
  localparam int W      = 1 + IDX_W + 1 + DATA_W;  // {last, edge, sign, mag}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (DEG=8) ----------------
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [2*DATA_W-1:0]  in_min = '0;
  logic [IDX_W-1:0]     in_idx = '0;
  logic [DEG-1:0]       in_signs = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DATA_W:0]      out_msg;
  logic [IDX_W-1:0]     out_edge;
  logic                 out_last;

  cnu_msg_gen #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEG(DEG), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_min(in_min), .in_idx(in_idx), .in_signs(in_signs),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_msg(out_msg), .out_edge(out_edge), .out_last(out_last)
  );

  // ---------------- DUT (DEG=6) ----------------
  logic                 s_in_valid = 1'b0;
  logic                 s_in_ready;
  logic [2*DATA_W-1:0]  s_in_min = '0;
  logic [IDX_W-1:0]     s_in_idx = '0;
  logic [DEG6-1:0]      s_in_signs = '0;
  logic                 s_out_valid;
  logic                 s_out_ready = 1'b1;
  logic [DATA_W:0]      s_out_msg;
  logic [IDX_W-1:0]     s_out_edge;
  logic                 s_out_last;

  cnu_msg_gen #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEG(DEG6), .OFFSET(OFFSET)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_min(s_in_min), .in_idx(s_in_idx), .in_signs(s_in_signs),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_msg(s_out_msg), .out_edge(s_out_edge), .out_last(s_out_last)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model.
  // Edge e carries the smaller of the other edges' magnitudes, offset and
  // floored at zero. Its sign is the XOR of all the other edges' signs.
  function automatic logic [W-1:0] model_beat(input int d, input int m1, input int m2,
                                              input int idx, input logic [7:0] sg, input int e);
    int   others_min;
    int   mag;
    logic s;
    logic [7:0] mask;
    mask = 8'((1 << d) - 1);
    others_min = (e == idx) ? m2 : m1;
    mag = (others_min > OFFSET) ? others_min - OFFSET : 0;
    s = (^(sg & mask)) ^ sg[e];
    return {(e == d - 1) ? 1'b1 : 1'b0, IDX_W'(e), s, DATA_W'(mag)};
  endfunction

  // ---------------- ready driver ----------------
  // mode 0: always ready, 1: random, 2: stall three cycles on edge 2
  int rdy_mode  = 0;
  int stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (out_valid && out_edge == 3'd2 && stall_cnt < 3) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  end

  // ---------------- scoreboard / monitor ----------------
  logic         held = 1'b0;
  logic [W-1:0] held_val = '0;

  always @(negedge clk) begin
    int recs, head_rem;
    logic hs_last;
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      recs     = (exp_q.size() + DEG - 1) / DEG;
      head_rem = exp_q.size() - (recs > 0 ? (recs - 1) * DEG : 0);
      hs_last  = out_ready && (recs > 0) && (head_rem == 1);
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, (recs < 2) || (recs == 2 && hs_last));
      if (held) check("hold_stable", {out_last, out_edge, out_msg}, held_val);
      held     = out_valid && !out_ready;
      held_val = {out_last, out_edge, out_msg};
      if (out_valid && out_ready && exp_q.size() != 0)
        check("beat", {out_last, out_edge, out_msg}, exp_q.pop_front());
      if (in_valid && in_ready)
        for (int e = 0; e < DEG; e++)
          exp_q.push_back(model_beat(DEG, int'(in_min[DATA_W-1:0]),
                                     int'(in_min[2*DATA_W-1:DATA_W]),
                                     int'(in_idx), in_signs, e));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int m1, input int m2, input int idx, input logic [7:0] sg);
    in_min   = {DATA_W'(m2), DATA_W'(m1)};
    in_idx   = IDX_W'(idx);
    in_signs = sg;
    in_valid = 1'b1;
    for (int t = 0; t <= 200; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t == 200) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t <= 2000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
      if (t == 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL idle_timeout: %0d beats outstanding, expected 0", exp_q.size());
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0] sg6;
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_msg", out_msg, 0);
    check("rst_out_edge", out_edge, 0);
    check("rst_out_last", out_last, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // DEG=6 instance, idx=7 is out of range, so every edge uses min1
    sg6 = 6'b101101;
    s_in_min   = {9'd3, 9'd20};
    s_in_idx   = 3'd7;
    s_in_signs = sg6;
    s_in_valid = 1'b1;
    @(negedge clk);
    check("deg6_in_ready", s_in_ready, 1);
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    for (int e = 0; e < DEG6; e++) begin
      @(negedge clk);
      check("deg6_valid", s_out_valid, 1);
      check("deg6_beat", {s_out_last, s_out_edge, s_out_msg},
            model_beat(DEG6, 20, 3, 7, {2'b00, sg6}, e));
    end
    @(negedge clk);
    check("deg6_done", s_out_valid, 0);
    @(posedge clk);
    #1;

    // Directed records
    send(5, 12, 3, 8'b0000_0101);
    wait_idle();
    send(0, 1, 6, 8'hFF);
    wait_idle();

    // Stall on edge 2
    rdy_mode = 2;
    send(5, 12, 3, 8'b0000_0101);
    wait_idle();
    check("stall_cycles", stall_cnt, 3);
    rdy_mode = 0;

    // Three back-to-back records
    for (int r = 0; r < 3; r++)
      send($urandom_range(0, 200), $urandom_range(200, 511), $urandom_range(0, 7), 8'($urandom));
    wait_idle();

    // Reset mid-record, with a second record stored behind the first
    send(9, 30, 1, 8'($urandom));
    send(4, 7, 5, 8'($urandom));
    for (int t = 0; t <= 100; t++) begin
      @(negedge clk);
      if (out_valid && out_edge == 3'd4) break;
      if (t == 100) begin
        n_vec++;
        n_err++;
        $display("FAIL edge4_timeout: edge 4 not seen, expected within 100 cycles");
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_edge", out_edge, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_out_msg", out_msg, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Random records with random back-pressure
    rdy_mode = 1;
    for (int r = 0; r < 40; r++) begin
      int m1, m2;
      m1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 511);
      m2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 511);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send(m1, m2, $urandom_range(0, 7), 8'($urandom));
    end
    wait_idle();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
